// File: rtl/ultrasound_pkg.sv
// Shared constants and state encoding for the 90 kHz launch / shot-scheduling / ADC capture path.
// No logic, no latency; no flow control.
// Contents: CLK_HZ, default timing constants in clk_50M cycles, scheduler state type,
// cycles-from-microseconds helper.
package ultrasound_pkg;

  localparam int CLK_HZ = 50_000_000;

  // Default timing, in clk_50M cycles, shared with the launcher and ADC capture blocks.
  localparam int PERIOD_CYC_DEF = 500_000;  // 10 ms shot-to-shot
  localparam int BURST_CYC_DEF  = 1_667;    // launcher excitation length
  localparam int WIN_DLY_DEF    = 2_500;    // 50 us blanking after launch
  localparam int WIN_LEN_DEF    = 50_000;   // 1 ms echo capture window
  localparam int NSHOT_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } shot_state_t;

  function automatic int cyc_from_us(input int us);
    return (CLK_HZ / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/us_period_timer.sv
// Shot period timer: counts cycles since the current launch, flags terminal count and shapes rx_win.
// Latency: cnt is 0 in the launch cycle; tc is combinational from cnt; rx_win is registered.
// Backpressure: none; clr has priority over en, win_clr forces rx_win low on the next edge.
// Ports: clk_50M, rst_n (async, active-low), clr / en (counter control), win_clr (abort window),
//        tc (cnt == PERIOD_CYC-1), rx_win (echo window).
// Build option: ECHO_WIN_EN enables the rx_win generator; otherwise rx_win is tied 0.
module us_period_timer
  import ultrasound_pkg::*;
#(
  parameter int PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int BURST_CYC  = BURST_CYC_DEF,
  parameter int WIN_DLY    = WIN_DLY_DEF,
  parameter int WIN_LEN    = WIN_LEN_DEF,
  parameter int PER_W      = $clog2(PERIOD_CYC)
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic win_clr,
  output logic tc,
  output logic rx_win
);

  logic [PER_W-1:0] cnt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PER_W'(1);
    end
  end

  // The burst term never gates a legal configuration (PERIOD_CYC > BURST_CYC); it keeps a
  // mis-set period from ever re-triggering the launcher mid-burst.
  assign tc = (cnt == PER_W'(PERIOD_CYC - 1)) && (cnt >= PER_W'(BURST_CYC));

`ifdef ECHO_WIN_EN
  logic win_rise;
  logic win_fall;

  // rx_win is registered, so the compares fire one count early: high for counts
  // WIN_DLY .. WIN_DLY+WIN_LEN-1 relative to the launch cycle.
  assign win_rise = (cnt == PER_W'(WIN_DLY - 1));
  assign win_fall = (cnt == PER_W'(WIN_DLY + WIN_LEN - 1));

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_win <= 1'b0;
    end else if (win_clr) begin
      rx_win <= 1'b0;
    end else if (win_rise) begin
      rx_win <= 1'b1;
    end else if (win_fall) begin
      rx_win <= 1'b0;
    end
  end
`else
  logic unused_win;

  assign rx_win     = 1'b0;
  assign unused_win = win_clr | (WIN_DLY > 0) | (WIN_LEN > 0);
`endif

endmodule

// File: rtl/ultrasound_shot_scheduler.sv
// Shot scheduler: issues one-cycle launch_cmd pulses every PERIOD_CYC cycles for shot_num shots
// (0 = continuous). Latency: first launch_cmd one cycle after an accepted start.
// Backpressure: none; start is ignored while busy, stop aborts on the next edge and beats start.
// Ports: clk_50M, rst_n (async, active-low), start/stop (one-cycle requests), shot_num (sampled
//        on accepted start), launch_cmd, busy, shot_cnt, done, rx_win (echo capture window).
// Build option: ECHO_WIN_EN enables rx_win; otherwise rx_win is constant 0.
module ultrasound_shot_scheduler
  import ultrasound_pkg::*;
#(
  parameter int PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int BURST_CYC  = BURST_CYC_DEF,
  parameter int NSHOT_W    = NSHOT_W_DEF,
  parameter int WIN_DLY    = WIN_DLY_DEF,
  parameter int WIN_LEN    = WIN_LEN_DEF
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NSHOT_W-1:0] shot_num,
  output logic               launch_cmd,
  output logic               busy,
  output logic [NSHOT_W-1:0] shot_cnt,
  output logic               done,
  output logic               rx_win
);

  shot_state_t        state;
  shot_state_t        state_nxt;
  logic [NSHOT_W-1:0] shot_num_q;
  logic               tc;
  logic               more_shots;
  logic               accept;
  logic               tmr_clr;
  logic               tmr_en;
  logic               win_clr;

  // shot_cnt already includes the launch just issued when WAIT reaches terminal count.
  assign more_shots = (shot_num_q == '0) || (shot_cnt < shot_num_q);
  assign accept     = (state == IDLE) && start && !stop;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    launch_cmd = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !stop) begin
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        launch_cmd = 1'b1;
        state_nxt  = stop ? IDLE : WAIT;
      end
      WAIT: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (tc) begin
          state_nxt = more_shots ? FIRE : DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      shot_num_q <= '0;
      shot_cnt   <= '0;
    end else if (accept) begin
      shot_num_q <= shot_num;
      shot_cnt   <= '0;
    end else if (state == FIRE) begin
      // Wraps naturally in continuous mode.
      shot_cnt <= shot_cnt + NSHOT_W'(1);
    end
  end

  // Counter reads 0 in the FIRE cycle and PERIOD_CYC-1 in the last WAIT cycle, giving
  // launch-to-launch spacing of exactly PERIOD_CYC.
  assign tmr_clr = (state_nxt != WAIT);
  assign tmr_en  = (state_nxt == WAIT);
  assign win_clr = (state_nxt == IDLE);

  us_period_timer #(
    .PERIOD_CYC (PERIOD_CYC),
    .BURST_CYC  (BURST_CYC),
    .WIN_DLY    (WIN_DLY),
    .WIN_LEN    (WIN_LEN)
  ) u_timer (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .win_clr (win_clr),
    .tc      (tc),
    .rx_win  (rx_win)
  );

endmodule
